ex_mem_stage: RTL
=================

// Module: ex_mem_stage
// PURPOSE
//  EX/MEM pipeline stage directly downstream of the execute ALU.
//  Captures the ALU result, Zero flag, store data, destination register and control bits.
//  Resolves conditional branches and presents entries to the MEM stage through a
//  DEPTH-entry in-order skid FIFO with a valid/ready handshake.
//  Drives the forwarding tap for the hazard/forwarding unit.
// PARAMETERS
//  DATA_W   32  datapath width (ALU result, store data, branch target)
//  REG_AW   5   register-number width
//  DEPTH    2   FIFO entries; power of two, >= 2
// PORTS
//  clk             in   1       clock; all state updates on rising edge
//  rst             in   1       synchronous, active-high reset
//  ex_valid        in   1       EX presents an instruction
//  ex_ready        out  1       stage can accept; = (count != DEPTH) && !rst; from registered state only
//  flush           in   1       kill the instruction presented this cycle
//  alu_out         in   DATA_W  ALU Output
//  zero            in   1       ALU Zero
//  store_data      in   DATA_W  rt value for stores
//  dest_reg        in   REG_AW  write-back register number
//  ctrl            in   5       {Branch, MemRead, MemWrite, RegWrite, MemtoReg}
//  branch_target   in   DATA_W  PC+4+offset<<2 from EX
//  mem_valid       out  1       head entry valid (count != 0)
//  mem_ready       in   1       MEM consumes head this cycle
//  mem_alu_out     out  DATA_W  head: address / result
//  mem_store_data  out  DATA_W  head: store data
//  mem_dest_reg    out  REG_AW  head: destination
//  mem_ctrl        out  4       head: {MemRead, MemWrite, RegWrite, MemtoReg}
//  pc_src          out  1       registered one-cycle pulse: branch taken
//  pc_branch       out  DATA_W  registered taken-branch target; held until next taken branch
//  fwd_valid       out  1       mem_valid && RegWrite && !MemtoReg at head
//  fwd_reg         out  REG_AW  = mem_dest_reg
//  fwd_data        out  DATA_W  = mem_alu_out
//  stall_cnt       out  16      perf counter (see CONFIGURATION)
//  bubble_cnt      out  16      perf counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: count=0, rd/wr ptr=0, mem_valid=0, pc_src=0, pc_branch=0, counters=0.
//  Reset overrides any operation in flight; FIFO contents are discarded.
//  accept = ex_valid && ex_ready && !flush.
//  Accepted non-branch entry is written at wr_ptr.
//   - It appears on mem_* the next cycle if the FIFO was empty: 1-cycle latency.
//  Branch entries (ctrl[4]=1) are never enqueued.
//   - Accepted branch with zero=1: pc_src=1 the next cycle only; pc_branch=branch_target.
//   - Accepted branch with zero=0: pc_src stays 0; pc_branch unchanged.
//  pop = mem_valid && mem_ready; advances rd_ptr.
//  Simultaneous push and pop: count unchanged; pointers both advance.
//   - With DEPTH=2, push+pop at count=1 is legal. At count=DEPTH, ex_ready=0, so no push.
//  Pointers wrap modulo DEPTH. Strict in-order delivery.
//  ex_ready does not depend on mem_ready; there is no combinational path from mem_ready to ex_ready.
//  flush drops only the presented input; entries already in the FIFO are older and still drain.
//  dest_reg==0: RegWrite is cleared at capture, so $0 is never written or forwarded.
//  mem_* outputs are don't-care while mem_valid=0. They must be stable while mem_valid && !mem_ready.
// CONFIGURATION
//  EXMEM_PERF_CNT_EN defined:
//   - stall_cnt += 1 each cycle with ex_valid && !ex_ready.
//   - bubble_cnt += 1 each cycle with ex_valid && flush.
//   - Both counters saturate at 16'hFFFF and are cleared by rst.
//  EXMEM_PERF_CNT_EN undefined: no counter logic; stall_cnt and bubble_cnt tied to 0.
// TESTING
//  1 Reset: fill to count=2, assert rst for 1 cycle
//    -> next cycle mem_valid=0, ex_ready=1, pc_src=0, pc_branch=0.
//  2 Passthrough: mem_ready=1; accept alu_out=32'h10, dest=8, ctrl=5'b00010
//    -> next cycle mem_valid=1, mem_alu_out=32'h10, fwd_valid=1, fwd_reg=8; following cycle mem_valid=0.
//  3 Backpressure: mem_ready=0; push results 1, 2, 3 on consecutive cycles
//    -> ex_ready=0 after 2 accepts; 3 held upstream; raise mem_ready -> mem_alu_out order 1,2,3, no loss.
//  4 Branch: ctrl=5'b10000, zero=1, target=32'h0040_0020
//    -> pc_src=1 for exactly 1 cycle, pc_branch=32'h0040_0020, mem_valid stays 0.
//    Repeat with zero=0 -> pc_src=0.
//  5 Flush: ex_valid=1, flush=1, dest=9
//    -> nothing enqueued; with EXMEM_PERF_CNT_EN, bubble_cnt=1.
//    Stall 3 cycles at full -> stall_cnt=3.
//  6 $0 write: dest=0, ctrl=5'b00010 -> mem_ctrl[1]=0, fwd_valid=0.
//    Load entry (MemtoReg=1) -> fwd_valid=0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM stage: branch resolve, in-order skid FIFO to MEM, forwarding tap.
// Optional perf counters enabled by defining EXMEM_PERF_CNT_EN.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              zero,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_AW-1:0] dest_reg,
    input  logic [4:0]        ctrl,
    input  logic [DATA_W-1:0] branch_target,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_alu_out,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_AW-1:0] mem_dest_reg,
    output logic [3:0]        mem_ctrl,
    output logic              pc_src,
    output logic [DATA_W-1:0] pc_branch,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       bubble_cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] alu_q   [DEPTH];
    logic [DATA_W-1:0] sd_q    [DEPTH];
    logic [REG_AW-1:0] dest_q  [DEPTH];
    logic [3:0]        ctrl_q  [DEPTH];

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          accept, push, pop;
    logic [3:0]    ctrl_cap;

    assign ex_ready  = (count != CW'(DEPTH)) && !rst;
    assign accept    = ex_valid && ex_ready && !flush;
    assign push      = accept && !ctrl[4];
    assign mem_valid = (count != '0);
    assign pop       = mem_valid && mem_ready;

    // RegWrite is dropped for $0 so nothing downstream ever writes or forwards it.
    assign ctrl_cap = {ctrl[3], ctrl[2], ctrl[1] && (dest_reg != '0), ctrl[0]};

    always_ff @(posedge clk) begin
        if (push) begin
            alu_q[wr_ptr]  <= alu_out;
            sd_q[wr_ptr]   <= store_data;
            dest_q[wr_ptr] <= dest_reg;
            ctrl_q[wr_ptr] <= ctrl_cap;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_src    <= 1'b0;
            pc_branch <= '0;
        end else begin
            pc_src <= accept && ctrl[4] && zero;
            if (accept && ctrl[4] && zero) pc_branch <= branch_target;
        end
    end

    assign mem_alu_out    = alu_q[rd_ptr];
    assign mem_store_data = sd_q[rd_ptr];
    assign mem_dest_reg   = dest_q[rd_ptr];
    assign mem_ctrl       = ctrl_q[rd_ptr];

    assign fwd_valid = mem_valid && mem_ctrl[1] && !mem_ctrl[0];
    assign fwd_reg   = mem_dest_reg;
    assign fwd_data  = mem_alu_out;

`ifdef EXMEM_PERF_CNT_EN
    logic [15:0] stall_q, bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (ex_valid && !ex_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            if (ex_valid && flush && bubble_q != 16'hFFFF)    bubble_q <= bubble_q + 16'd1;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif
endmodule
